// File: rtl/pwr_pkg.sv
// Shared definitions for the power-domain response controller: FSM state
// encodings, violation codes, settle-time default and violation priority.
package pwr_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_OFF     = 3'd3,
    ST_RAMP    = 3'd4,
    ST_UP      = 3'd5,
    ST_RESTORE = 3'd6
  } pwr_state_e;

  localparam int unsigned PG_DLY_DEFAULT = 8;
  localparam int          CNT_W          = 8;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_PSE_NO_ISO = 3'd1;
  localparam logic [2:0] ERR_PSE_NO_RET = 3'd2;
  localparam logic [2:0] ERR_RET_NO_ISO = 3'd3;
  localparam logic [2:0] ERR_ISO_NO_PSE = 3'd4;

  // Same-cycle violations resolve in pse, ret, iso order.
  function automatic logic [2:0] viol_code(input logic pse_fall,
                                           input logic ret_rise,
                                           input logic iso_fall,
                                           input logic iso,
                                           input logic ret,
                                           input logic pse);
    logic [2:0] code;
    code = ERR_NONE;
    if (pse_fall && !iso)      code = ERR_PSE_NO_ISO;
    else if (pse_fall && !ret) code = ERR_PSE_NO_RET;
    else if (ret_rise && !iso) code = ERR_RET_NO_ISO;
    else if (iso_fall && !pse) code = ERR_ISO_NO_PSE;
    return code;
  endfunction

endpackage

// File: rtl/pwr_dom_resp_if.sv
// Signal bundle between the power controller (master) and the domain
// response block (slave).
interface pwr_dom_resp_if;

  // Level protocol, no valid/ready: the controller holds iso_en/ret_en/pse
  // as levels and the block reacts to their sampled edges; save_req and
  // restore_req are single-cycle pulses, every other output is a level.
  logic       iso_en;
  logic       ret_en;
  logic       pse;
  logic       dom_clk_en;
  logic       dom_rst_n;
  logic       pwr_good;
  logic       save_req;
  logic       restore_req;
  logic       busy;
  logic       err;
  logic [2:0] err_code;
  logic [2:0] dom_state;

  modport master (
    output iso_en, ret_en, pse,
    input  dom_clk_en, dom_rst_n, pwr_good, save_req, restore_req,
    input  busy, err, err_code, dom_state
  );

  modport slave (
    input  iso_en, ret_en, pse,
    output dom_clk_en, dom_rst_n, pwr_good, save_req, restore_req,
    output busy, err, err_code, dom_state
  );

endinterface

// File: rtl/pwr_settle_cnt.sv
// Rail settle counter: counts enabled cycles up to PG_DLY and saturates;
// o_done flags the cycle whose increment reaches PG_DLY.
module pwr_settle_cnt
  import pwr_pkg::*;
#(
  parameter int unsigned PG_DLY = PG_DLY_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LP_TOP  = CNT_W'(PG_DLY);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(PG_DLY - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LP_TOP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_done = i_enable && !i_clear && (r_cnt == LP_LAST);

endmodule

// File: rtl/pwr_dom_resp.sv
// Power-domain response controller: sequences isolation, retention save,
// rail off/ramp, domain reset release and restore from controller requests.
module pwr_dom_resp
  import pwr_pkg::*;
#(
  parameter int unsigned PG_DLY = PG_DLY_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  pwr_dom_resp_if.slave  bus
);

  logic       r_iso, r_ret, r_pse;
  logic       r_iso_d, r_ret_d, r_pse_d;
  logic [1:0] r_boot;
  pwr_state_e r_state;
  logic       r_clk_en, r_dom_rst_n, r_pwr_good;
  logic       r_save_req, r_restore_req, r_ret_valid;
  logic       r_err;
  logic [2:0] r_err_code;

  pwr_state_e w_nxt_state;
  logic       w_nxt_clk_en, w_nxt_dom_rst_n, w_nxt_pwr_good;
  logic       w_nxt_save_req, w_nxt_restore_req, w_nxt_ret_valid;
  logic       w_nxt_err;
  logic [2:0] w_nxt_err_code;
  logic       w_live, w_pse_rise, w_pse_fall, w_ret_rise, w_iso_rise, w_iso_fall;
  logic [2:0] w_viol;
  logic       w_cnt_clear, w_cnt_en, w_cnt_done;

  // Inputs are sampled once; edges compare the sample with the one before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iso   <= 1'b0;
      r_ret   <= 1'b0;
      r_pse   <= 1'b0;
      r_iso_d <= 1'b0;
      r_ret_d <= 1'b0;
      r_pse_d <= 1'b0;
      r_boot  <= 2'b11;
    end else begin
      r_iso   <= bus.iso_en;
      r_ret   <= bus.ret_en;
      r_pse   <= bus.pse;
      r_iso_d <= r_iso;
      r_ret_d <= r_ret;
      r_pse_d <= r_pse;
      r_boot  <= {r_boot[0], 1'b0};
    end
  end

  // r_boot masks the fake 0->1 edges seen while the input pipe first fills.
  assign w_live     = (r_boot == 2'b00);
  assign w_pse_rise = w_live &  r_pse & ~r_pse_d;
  assign w_pse_fall = w_live & ~r_pse &  r_pse_d;
  assign w_ret_rise = w_live &  r_ret & ~r_ret_d;
  assign w_iso_rise = w_live &  r_iso & ~r_iso_d;
  assign w_iso_fall = w_live & ~r_iso &  r_iso_d;
  assign w_viol     = viol_code(w_pse_fall, w_ret_rise, w_iso_fall, r_iso, r_ret, r_pse);

  pwr_settle_cnt #(.PG_DLY(PG_DLY)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_done   (w_cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_clk_en      <= 1'b1;
      r_dom_rst_n   <= 1'b0;
      r_pwr_good    <= 1'b1;
      r_save_req    <= 1'b0;
      r_restore_req <= 1'b0;
      r_ret_valid   <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_state       <= w_nxt_state;
      r_clk_en      <= w_nxt_clk_en;
      r_dom_rst_n   <= w_nxt_dom_rst_n;
      r_pwr_good    <= w_nxt_pwr_good;
      r_save_req    <= w_nxt_save_req;
      r_restore_req <= w_nxt_restore_req;
      r_ret_valid   <= w_nxt_ret_valid;
      r_err         <= w_nxt_err;
      r_err_code    <= w_nxt_err_code;
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_clk_en      = r_clk_en;
    w_nxt_dom_rst_n   = r_dom_rst_n;
    w_nxt_pwr_good    = r_pwr_good;
    w_nxt_save_req    = 1'b0;
    w_nxt_restore_req = 1'b0;
    w_nxt_ret_valid   = r_ret_valid;
    w_nxt_err         = r_err;
    w_nxt_err_code    = r_err_code;
    w_cnt_clear       = 1'b0;
    w_cnt_en          = 1'b0;

    if (!r_err && (w_viol != ERR_NONE)) begin
      w_nxt_err      = 1'b1;
      w_nxt_err_code = w_viol;
    end

    if (r_boot == 2'b10) begin
      // First real sample of pse decides between releasing reset and OFF.
      if (r_pse) begin
        w_nxt_dom_rst_n = 1'b1;
      end else begin
        w_nxt_state    = ST_OFF;
        w_nxt_clk_en   = 1'b0;
        w_nxt_pwr_good = 1'b0;
        w_cnt_clear    = 1'b1;
      end
    end else if (w_pse_fall) begin
      w_nxt_state     = ST_OFF;
      w_nxt_clk_en    = 1'b0;
      w_nxt_pwr_good  = 1'b0;
      w_nxt_dom_rst_n = 1'b0;
      w_cnt_clear     = 1'b1;
    end else if (w_live) begin
      case (r_state)
        ST_RUN: begin
          if (w_iso_rise && r_pse) begin
            w_nxt_state  = ST_ISO;
            w_nxt_clk_en = 1'b0;
          end
        end
        ST_ISO: begin
          if (w_ret_rise) begin
            w_nxt_state     = ST_SAVE;
            w_nxt_save_req  = 1'b1;
            w_nxt_ret_valid = 1'b1;
          end else if (w_iso_fall) begin
            w_nxt_state  = ST_RUN;
            w_nxt_clk_en = 1'b1;
          end
        end
        ST_SAVE: begin
          w_nxt_state = ST_SAVE;
        end
        ST_OFF: begin
          if (w_pse_rise) begin
            w_nxt_state = ST_RAMP;
            w_cnt_en    = 1'b1;
            if (w_cnt_done) w_nxt_pwr_good = 1'b1;
          end
        end
        ST_RAMP: begin
          w_cnt_en = r_pse;
          if (w_cnt_done) w_nxt_pwr_good = 1'b1;
          if (r_pwr_good) begin
            w_nxt_state     = ST_UP;
            w_nxt_dom_rst_n = 1'b1;
          end
        end
        ST_UP: begin
          // ret and iso are checked as levels so early drops are simply deferred.
          if (r_ret_valid && !r_ret && r_dom_rst_n) begin
            w_nxt_state       = ST_RESTORE;
            w_nxt_restore_req = 1'b1;
          end else if (!r_ret_valid && !r_iso && r_dom_rst_n) begin
            w_nxt_state  = ST_RUN;
            w_nxt_clk_en = 1'b1;
          end
        end
        ST_RESTORE: begin
          w_nxt_ret_valid = 1'b0;
          if (!r_iso) begin
            w_nxt_state  = ST_RUN;
            w_nxt_clk_en = 1'b1;
          end
        end
        default: begin
          w_nxt_state = ST_RUN;
        end
      endcase
    end
  end

  assign bus.dom_clk_en  = r_clk_en;
  assign bus.dom_rst_n   = r_dom_rst_n;
  assign bus.pwr_good    = r_pwr_good;
  assign bus.save_req    = r_save_req;
  assign bus.restore_req = r_restore_req;
  assign bus.busy        = (r_state != ST_RUN);
  assign bus.err         = r_err;
  assign bus.err_code    = r_err_code;
  assign bus.dom_state   = r_state;

endmodule

// File: tb/tb_pwr_dom_resp.sv
// Bench for pwr_dom_resp: vector table of iso/ret/pse steps with expected
// levels, a pulse scoreboard for save/restore, and hand-written ramp/reset cases.
module tb_pwr_dom_resp;
  import pwr_pkg::*;

  localparam int PG = 8;
  localparam logic [1:0] EV_NONE    = 2'b00;
  localparam logic [1:0] EV_SAVE    = 2'b01;
  localparam logic [1:0] EV_RESTORE = 2'b10;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pwr_dom_resp_if bus();

  pwr_dom_resp #(.PG_DLY(PG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    bit         rst;
    logic [2:0] in;
    int         cyc;
    logic [1:0] ev;
    pwr_state_e st;
    logic       ce;
    logic       dr;
    logic       pg;
    logic       er;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [2:0] in, input int cyc,
                     input logic [1:0] ev, input pwr_state_e st, input logic ce,
                     input logic dr, input logic pg, input logic er,
                     input logic [2:0] code);
    vec_t v;
    v.rst = rst; v.in = in; v.cyc = cyc; v.ev = ev; v.st = st;
    v.ce = ce; v.dr = dr; v.pg = pg; v.er = er; v.code = code;
    vecs.push_back(v);
  endtask

  // Inputs in {iso_en, ret_en, pse} order.
  task automatic drive(input logic [2:0] in, input logic [1:0] ev);
    if (ev != EV_NONE) exp_q.push_back(ev);
    bus.iso_en = in[2];
    bus.ret_en = in[1];
    bus.pse    = in[0];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},   int'(bus.dom_state),   int'(ST_RUN));
    check({tag, "_clk_en"},  int'(bus.dom_clk_en),  1);
    check({tag, "_rst_n"},   int'(bus.dom_rst_n),   0);
    check({tag, "_pg"},      int'(bus.pwr_good),    1);
    check({tag, "_save"},    int'(bus.save_req),    0);
    check({tag, "_restore"}, int'(bus.restore_req), 0);
    check({tag, "_err"},     int'(bus.err),         0);
    check({tag, "_code"},    int'(bus.err_code),    0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(3'b001, EV_NONE);
    wait_cyc(2);
    check_reset_vals("rst");
    rst_n = 1'b1;
    wait_cyc(2);
    check("boot_rst_n", int'(bus.dom_rst_n), 1);
    check("boot_state", int'(bus.dom_state), int'(ST_RUN));
  endtask

  task automatic pulse_seen(input logic [1:0] ev);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL pulse_unexpected: got %0d expected none", ev);
    end else begin
      check("pulse_event", int'(ev), int'(exp_q.pop_front()));
    end
  endtask

  // Every sampled high cycle counts as a pulse, so a stretched pulse shows
  // up as an unexpected extra event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.save_req)    pulse_seen(EV_SAVE);
      if (bus.restore_req) pulse_seen(EV_RESTORE);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hold;
    rst_n = 1'b0;
    drive(3'b001, EV_NONE);

    // Full controller sequence 001,101,111,110,111,101,001.
    add(1, 3'b001, 2, EV_NONE,    ST_RUN,     1, 1, 1, 0, 0);
    add(0, 3'b101, 2, EV_NONE,    ST_ISO,     0, 1, 1, 0, 0);
    add(0, 3'b111, 2, EV_SAVE,    ST_SAVE,    0, 1, 1, 0, 0);
    add(0, 3'b110, 2, EV_NONE,    ST_OFF,     0, 0, 0, 0, 0);
    add(0, 3'b111, 2, EV_NONE,    ST_RAMP,    0, 0, 0, 0, 0);
    add(0, 3'b111, 7, EV_NONE,    ST_RAMP,    0, 0, 1, 0, 0);
    add(0, 3'b111, 1, EV_NONE,    ST_UP,      0, 1, 1, 0, 0);
    add(0, 3'b101, 2, EV_RESTORE, ST_RESTORE, 0, 1, 1, 0, 0);
    add(0, 3'b001, 2, EV_NONE,    ST_RUN,     1, 1, 1, 0, 0);
    // Iso abort: no save.
    add(0, 3'b101, 2, EV_NONE,    ST_ISO,     0, 1, 1, 0, 0);
    add(0, 3'b001, 2, EV_NONE,    ST_RUN,     1, 1, 1, 0, 0);
    // pse drop in RUN, then power-up without retention straight to RUN.
    add(0, 3'b000, 2, EV_NONE,    ST_OFF,     0, 0, 0, 1, 1);
    add(0, 3'b001, 2, EV_NONE,    ST_RAMP,    0, 0, 0, 1, 1);
    add(0, 3'b001, 8, EV_NONE,    ST_UP,      0, 1, 1, 1, 1);
    add(0, 3'b001, 1, EV_NONE,    ST_RUN,     1, 1, 1, 1, 1);
    // Double violation keeps the first code.
    add(1, 3'b011, 2, EV_NONE,    ST_RUN,     1, 1, 1, 1, 3);
    add(0, 3'b010, 2, EV_NONE,    ST_OFF,     0, 0, 0, 1, 3);
    // pse falls during ISO without retention.
    add(1, 3'b101, 2, EV_NONE,    ST_ISO,     0, 1, 1, 0, 0);
    add(0, 3'b100, 2, EV_NONE,    ST_OFF,     0, 0, 0, 1, 2);
    // iso falls while the rail is off.
    add(1, 3'b101, 2, EV_NONE,    ST_ISO,     0, 1, 1, 0, 0);
    add(0, 3'b111, 2, EV_SAVE,    ST_SAVE,    0, 1, 1, 0, 0);
    add(0, 3'b110, 2, EV_NONE,    ST_OFF,     0, 0, 0, 0, 0);
    add(0, 3'b100, 2, EV_NONE,    ST_OFF,     0, 0, 0, 0, 0);
    add(0, 3'b000, 2, EV_NONE,    ST_OFF,     0, 0, 0, 1, 4);
    // ret falls during RAMP: restore deferred to UP, no error.
    add(1, 3'b101, 2, EV_NONE,    ST_ISO,     0, 1, 1, 0, 0);
    add(0, 3'b111, 2, EV_SAVE,    ST_SAVE,    0, 1, 1, 0, 0);
    add(0, 3'b110, 2, EV_NONE,    ST_OFF,     0, 0, 0, 0, 0);
    add(0, 3'b111, 2, EV_NONE,    ST_RAMP,    0, 0, 0, 0, 0);
    add(0, 3'b101, 2, EV_NONE,    ST_RAMP,    0, 0, 0, 0, 0);
    add(0, 3'b101, 5, EV_NONE,    ST_RAMP,    0, 0, 1, 0, 0);
    add(0, 3'b101, 1, EV_RESTORE, ST_UP,      0, 1, 1, 0, 0);
    add(0, 3'b101, 1, EV_NONE,    ST_RESTORE, 0, 1, 1, 0, 0);
    add(0, 3'b001, 2, EV_NONE,    ST_RUN,     1, 1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) apply_reset();
      drive(vecs[i].in, vecs[i].ev);
      wait_cyc(vecs[i].cyc);
      check($sformatf("v%0d_state", i),  int'(bus.dom_state),  int'(vecs[i].st));
      check($sformatf("v%0d_clk_en", i), int'(bus.dom_clk_en), int'(vecs[i].ce));
      check($sformatf("v%0d_rst_n", i),  int'(bus.dom_rst_n),  int'(vecs[i].dr));
      check($sformatf("v%0d_pg", i),     int'(bus.pwr_good),   int'(vecs[i].pg));
      check($sformatf("v%0d_busy", i),   int'(bus.busy),       (vecs[i].st != ST_RUN) ? 1 : 0);
      check($sformatf("v%0d_err", i),    int'(bus.err),        int'(vecs[i].er));
      check($sformatf("v%0d_code", i),   int'(bus.err_code),   int'(vecs[i].code));
    end

    // Rail drops mid-ramp; the next ramp must take the full settle time.
    apply_reset();
    drive(3'b101, EV_NONE);  wait_cyc(2);
    drive(3'b111, EV_SAVE);  wait_cyc(2);
    drive(3'b110, EV_NONE);  wait_cyc(2);
    check("ramp_off_state", int'(bus.dom_state), int'(ST_OFF));
    drive(3'b111, EV_NONE);  wait_cyc(5);
    check("ramp4_state", int'(bus.dom_state), int'(ST_RAMP));
    check("ramp4_pg", int'(bus.pwr_good), 0);
    drive(3'b110, EV_NONE);  wait_cyc(2);
    check("redrop_state", int'(bus.dom_state), int'(ST_OFF));
    check("redrop_pg", int'(bus.pwr_good), 0);
    check("redrop_rst_n", int'(bus.dom_rst_n), 0);
    check("redrop_err", int'(bus.err), 0);
    drive(3'b111, EV_NONE);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.pwr_good) begin
        k = c;
        break;
      end
    end
    // One cycle of input registration plus PG settle cycles.
    check("pg_latency", k, PG + 1);
    check("rst_n_at_pg", int'(bus.dom_rst_n), 0);
    wait_cyc(1);
    check("rst_n_after_pg", int'(bus.dom_rst_n), 1);
    check("up_state", int'(bus.dom_state), int'(ST_UP));

    // Reset asserted mid-ramp with a recorded error.
    apply_reset();
    drive(3'b000, EV_NONE);  wait_cyc(2);
    check("pre_rst_code", int'(bus.err_code), 1);
    hold = $urandom_range(0, 5);
    drive(3'b001, EV_NONE);  wait_cyc(2 + hold);
    check("pre_rst_state", int'(bus.dom_state), int'(ST_RAMP));
    rst_n = 1'b0;
    #1;
    check_reset_vals("midramp");
    apply_reset();

    wait_cyc(3);
    check("pending_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
